// File: rtl/div_seq_if.sv
// Request/response bundle between the EX stage and the iterative divider.
// EX drives the master side; the divider implements the slave side.
interface div_seq_if;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stallreq_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o, stallreq_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o, stallreq_o
   );
endinterface

// File: rtl/div_seq.sv
// Restoring 32-bit divider, one quotient bit per cycle, for div/divu in EX.
// Returns {remainder, quotient}; stalls the pipeline while a request is pending.
module div_seq (
   input logic      clk,
   input logic      rst,
   div_seq_if.slave bus
);
   typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

   state_t      state, state_nxt;
   logic [5:0]  cnt, cnt_nxt;
   logic [63:0] result, result_nxt;
   logic [63:0] dividend, dividend_nxt;
   logic [31:0] divisor, divisor_nxt;
   logic        qneg, qneg_nxt;
   logic        rneg, rneg_nxt;

   logic [31:0]        mag1, mag2;
   logic               sign1, sign2;
   logic signed [32:0] diff;

   // Two's complement negate with 32-bit wrap-around (0x80000000 maps to itself).
   function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
      return neg ? (~v + 32'd1) : v;
   endfunction

   assign sign1 = bus.signed_div_i & bus.opdata1_i[31];
   assign sign2 = bus.signed_div_i & bus.opdata2_i[31];
   assign mag1  = neg_if(sign1, bus.opdata1_i);
   assign mag2  = neg_if(sign2, bus.opdata2_i);

   // Window [63:31] holds partial remainder * 2 plus the next dividend bit.
   assign diff = $signed(dividend[63:31] - {1'b0, divisor});

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      result_nxt   = result;
      dividend_nxt = dividend;
      divisor_nxt  = divisor;
      qneg_nxt     = qneg;
      rneg_nxt     = rneg;
      case (state)
         S_FREE: begin
            if (bus.start_i && !bus.annul_i) begin
               if (bus.opdata2_i == 32'd0) begin
                  state_nxt = S_BYZERO;
               end else begin
                  divisor_nxt  = mag2;
                  dividend_nxt = {32'd0, mag1};
                  qneg_nxt     = sign1 ^ sign2;
                  rneg_nxt     = sign1;
                  cnt_nxt      = 6'd0;
                  state_nxt    = S_ON;
               end
            end
         end
         S_BYZERO: begin
            if (bus.annul_i) begin
               state_nxt = S_FREE;
            end else begin
               result_nxt = 64'd0;
               state_nxt  = S_END;
            end
         end
         S_ON: begin
            if (bus.annul_i || !bus.start_i) begin
               state_nxt = S_FREE;
            end else if (cnt != 6'd32) begin
               if (diff < 0)
                  dividend_nxt = {dividend[62:0], 1'b0};
               else
                  dividend_nxt = {diff[31:0], dividend[30:0], 1'b1};
               cnt_nxt = cnt + 6'd1;
            end else begin
               result_nxt = {neg_if(rneg, dividend[63:32]), neg_if(qneg, dividend[31:0])};
               state_nxt  = S_END;
            end
         end
         S_END: begin
            if (bus.annul_i || !bus.start_i)
               state_nxt = S_FREE;
         end
         default: state_nxt = S_FREE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_FREE;
         cnt    <= 6'd0;
         result <= 64'd0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         result <= result_nxt;
      end
   end

   // Datapath registers are only meaningful after acceptance, so they carry no reset.
   always_ff @(posedge clk) begin
      dividend <= dividend_nxt;
      divisor  <= divisor_nxt;
      qneg     <= qneg_nxt;
      rneg     <= rneg_nxt;
   end

   assign bus.result_o   = result;
   assign bus.ready_o    = (state == S_END);
   assign bus.stallreq_o = !rst && bus.start_i && (state != S_END);
endmodule
